// File: rtl/crc_ccitt_pkg.sv
// Shared types and constants for the CRC-CCITT scheduler slice.
// Polynomial 0x1021, MSB-first, no reflection, no final XOR.
package crc_ccitt_pkg;

    localparam int CRC_W = 16;
    localparam logic [CRC_W-1:0] POLY = 16'h1021;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        RESULT = 2'd3
    } sched_state_t;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_cur,
                                                   input logic bit_in);
        logic fb;
        fb = crc_cur[CRC_W-1] ^ bit_in;
        return {crc_cur[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

endpackage

// File: rtl/crc_ccitt_bit_engine.sv
// Bit-serial CRC-CCITT register: synchronous load of INIT, one LFSR step per
// enabled cycle. crc_nxt exposes the value the next shift will produce.
module crc_ccitt_bit_engine
    import crc_ccitt_pkg::*;
#(
    parameter logic [CRC_W-1:0] INIT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc,
    output logic [CRC_W-1:0] crc_nxt
);

    assign crc_nxt = crc_step(crc, bit_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (load) begin
            crc <= INIT;
        end else if (shift_en) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/crc_ccitt_sched.sv
// Frame-level round-robin scheduler sharing one bit-serial CRC-CCITT engine
// between NREQ byte streams. Optional mid-frame timeout: CRC_SCHED_TIMEOUT_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// ARB    | pick next requester from ptr, load INIT into the engine
// LOAD   | req_ready to granted requester, wait for a byte
// SHIFT  | feed the byte MSB first, one bit per cycle (8 cycles)
// RESULT | present res_*, hold until res_ready
module crc_ccitt_sched
    import crc_ccitt_pkg::*;
#(
    parameter int               NREQ    = 2,
    parameter logic [CRC_W-1:0] INIT    = 16'h0000,
    parameter int               TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [CRC_W-1:0]        res_crc,
    output logic                    res_err,
    input  logic                    res_ready
);

    localparam int GW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    sched_state_t     state;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    ptr;
    logic [GW-1:0]    arb_sel;
    logic [7:0]       sh;
    logic [2:0]       bcnt;
    logic             last_q;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             hs;
    logic             tmo_fire;
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crc_nxt;

    always_comb begin
        int  idx;
        logic hit;
        idx     = 0;
        hit     = 1'b0;
        arb_sel = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!hit && req_valid[idx]) begin
                hit     = 1'b1;
                arb_sel = GW'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == GW'(k)) begin
                sel_data = req_data[8*k +: 8];
                sel_last = req_last[k];
            end
        end
    end

    // req_ready is only ever one-hot at the grant while in LOAD
    assign hs = |(req_valid & req_ready);

    crc_ccitt_bit_engine #(
        .INIT(INIT)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ARB),
        .shift_en (state == SHIFT),
        .bit_in   (sh[7]),
        .crc      (crc),
        .crc_nxt  (crc_nxt)
    );

`ifdef CRC_SCHED_TIMEOUT_EN
    localparam logic [15:0] TMO_RLD = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_arm;
    logic        res_err_q;

    assign tmo_arm  = (state == ARB && |req_valid)
                   || (state == SHIFT && bcnt == 3'd7 && !last_q)
                   || (state == LOAD && hs);
    assign tmo_fire = (state == LOAD) && !hs && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (tmo_arm) begin
            tmo_cnt <= TMO_RLD;
        end else if (state == LOAD && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else if (tmo_fire) begin
            res_err_q <= 1'b1;
        end else if (state == RESULT && res_ready) begin
            res_err_q <= 1'b0;
        end
    end

    assign res_err = res_err_q;
`else
    logic unused_tmo;

    assign tmo_fire   = 1'b0;
    assign res_err    = 1'b0;
    assign unused_tmo = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            grant     <= '0;
            ptr       <= '0;
            sh        <= '0;
            bcnt      <= '0;
            last_q    <= 1'b0;
            req_ready <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_crc   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (|req_valid) begin
                        grant     <= arb_sel;
                        req_ready <= ONE << arb_sel;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        sh        <= sel_data;
                        last_q    <= sel_last;
                        bcnt      <= '0;
                        req_ready <= '0;
                        state     <= SHIFT;
                    end else if (tmo_fire) begin
                        req_ready <= '0;
                        res_valid <= 1'b1;
                        res_id    <= grant;
                        res_crc   <= crc;
                        state     <= RESULT;
                    end
                end
                SHIFT: begin
                    sh   <= {sh[6:0], 1'b0};
                    bcnt <= bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        if (last_q) begin
                            res_valid <= 1'b1;
                            res_id    <= grant;
                            res_crc   <= crc_nxt;
                            state     <= RESULT;
                        end else begin
                            req_ready <= ONE << grant;
                            state     <= LOAD;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= (grant == GW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        state     <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule
